// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Branch resolution between the execute stage and fetch control. Holds the
//   architectural flag register {V,C,S,Z}, accepts one branch request per
//   valid/ready handshake, and one cycle later emits registered resolve,
//   redirect and link pulses. After a taken branch the unit holds br_ready low
//   for FLUSH_CYCLES extra cycles while fetch refills. Saturating taken /
//   not-taken counters are kept for statistics.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   alu_result/carry/ovf       ALU outputs: flag source, or live condition source
//   flag_we                    latch {V,C,S,Z} from the ALU inputs
//   br_valid/br_ready          request handshake
//   br_opcode/br_pc/br_target  branch request fields
//   redirect_valid/redirect_pc one-cycle fetch redirect, target held between pulses
//   link_we/link_data          one-cycle link write of br_pc+4, value held between pulses
//   resolved                   one-cycle pulse per finished branch
//   flags                      {V,C,S,Z}
//   stat_clr                   synchronous clear of the counters (wins over increment)
//   taken_cnt/ntaken_cnt       saturating statistics counters
module branch_resolve_unit #(
  parameter int DATA_W       = 32,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16,
  parameter int FLAG_MODE    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              flag_we,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [5:0]        br_opcode,
  input  logic [PC_W-1:0]   br_pc,
  input  logic [PC_W-1:0]   br_target,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_pc,
  output logic              link_we,
  output logic [PC_W-1:0]   link_data,
  output logic              resolved,
  output logic [3:0]        flags,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  ntaken_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_FLUSH} state_t;

  localparam int             FCW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FCW-1:0] FLUSH_LD  = FCW'(FLUSH_CYCLES);
  localparam bit             HAS_FLUSH = (FLUSH_CYCLES > 0);

  localparam logic [5:0] OP_BLT  = 6'b001000;
  localparam logic [5:0] OP_BZ   = 6'b001001;
  localparam logic [5:0] OP_BNZ  = 6'b001010;
  localparam logic [5:0] OP_BR   = 6'b001011;
  localparam logic [5:0] OP_B    = 6'b001100;
  localparam logic [5:0] OP_BL   = 6'b001101;
  localparam logic [5:0] OP_BCY  = 6'b001110;
  localparam logic [5:0] OP_BNCY = 6'b001111;
  localparam logic [5:0] OP_BOV  = 6'b010000;
  localparam logic [5:0] OP_BGE  = 6'b010001;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // f = {V,C,S,Z}; unknown opcodes resolve as not taken
  function automatic logic cond_eval(input logic [5:0] op, input logic [3:0] f);
    logic z, s, c, v;
    {v, c, s, z} = f;
    case (op)
      OP_BLT:              return s & ~z;
      OP_BZ:               return z;
      OP_BNZ:              return ~z;
      OP_BR, OP_B, OP_BL:  return 1'b1;
      OP_BCY:              return c;
      OP_BNCY:             return ~c;
      OP_BOV:              return v;
      OP_BGE:              return ~s;
      default:             return 1'b0;
    endcase
  endfunction

  state_t         state, state_nxt;
  logic [FCW-1:0] fcnt;
  logic [3:0]     flag_q;
  logic [3:0]     live_flags;
  logic [3:0]     cond_flags;
  logic           acc_p0;
  logic           taken_p0;
  logic           link_p0;
  logic           vld_p1;
  logic           redir_p1;
  logic           link_we_p1;
  logic [PC_W-1:0] redir_pc_p1;
  logic [PC_W-1:0] link_data_p1;
  logic [CNT_W-1:0] tcnt_q, ncnt_q;

  // ---- p0: acceptance and condition evaluation ----
  // In flag mode the register value is read before this edge's flag_we update,
  // so a same-cycle flag write is not seen by the branch being accepted.
  assign live_flags = {alu_ovf, alu_carry, alu_result[DATA_W-1], (alu_result == '0)};
  assign cond_flags = (FLAG_MODE != 0) ? flag_q : live_flags;
  assign acc_p0     = br_valid & br_ready;
  assign taken_p0   = cond_eval(br_opcode, cond_flags);
  assign link_p0    = (br_opcode == OP_BL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 4'b0000;
    end else if (flag_we) begin
      flag_q <= live_flags;
    end
  end

  // ---- p1: registered pulses, visible during the RESOLVE cycle ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1       <= 1'b0;
      redir_p1     <= 1'b0;
      link_we_p1   <= 1'b0;
      redir_pc_p1  <= '0;
      link_data_p1 <= '0;
    end else begin
      vld_p1     <= acc_p0;
      redir_p1   <= acc_p0 & taken_p0;
      link_we_p1 <= acc_p0 & link_p0;
      if (acc_p0 && taken_p0) redir_pc_p1  <= br_target;
      if (acc_p0 && link_p0)  link_data_p1 <= br_pc + PC_W'(4);
    end
  end

  // ---- control: state register, flush counter, statistics ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt <= '0;
    end else if (state == S_RESOLVE && redir_p1) begin
      fcnt <= FLUSH_LD;
    end else if (state == S_FLUSH) begin
      fcnt <= fcnt - FCW'(1);
    end
  end

  // The RESOLVE cycle is where the outcome is counted; clear wins over it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      ncnt_q <= '0;
    end else if (stat_clr) begin
      tcnt_q <= '0;
      ncnt_q <= '0;
    end else if (state == S_RESOLVE) begin
      if (redir_p1) tcnt_q <= sat_inc(tcnt_q);
      else          ncnt_q <= sat_inc(ncnt_q);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (acc_p0) state_nxt = S_RESOLVE;
      S_RESOLVE: state_nxt = (redir_p1 && HAS_FLUSH) ? S_FLUSH : S_IDLE;
      S_FLUSH:   if (fcnt <= FCW'(1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Ready is gated by rst_n so it is low for the whole reset window and high
  // in the first cycle after release.
  always_comb begin
    br_ready = 1'b0;
    if (rst_n && state == S_IDLE) br_ready = 1'b1;
  end

  assign resolved       = vld_p1;
  assign redirect_valid = redir_p1;
  assign redirect_pc    = redir_pc_p1;
  assign link_we        = link_we_p1;
  assign link_data      = link_data_p1;
  assign flags          = flag_q;
  assign taken_cnt      = tcnt_q;
  assign ntaken_cnt     = ncnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int FL     = 2;
  localparam int CNT_W  = 2;
  localparam int CMAX   = 3;

  localparam logic [5:0] BLT = 6'b001000, BZ = 6'b001001, BNZ = 6'b001010,
                         B = 6'b001100, BL = 6'b001101, UNK = 6'b111111;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry, alu_ovf, flag_we;
  logic              br_valid, br_ready;
  logic [5:0]        br_opcode;
  logic [PC_W-1:0]   br_pc, br_target;
  logic              redirect_valid, link_we, resolved;
  logic [PC_W-1:0]   redirect_pc, link_data;
  logic [3:0]        flags;
  logic              stat_clr;
  logic [CNT_W-1:0]  taken_cnt, ntaken_cnt;

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .FLUSH_CYCLES(FL), .CNT_W(CNT_W), .FLAG_MODE(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_ovf(alu_ovf), .flag_we(flag_we), .br_valid(br_valid), .br_ready(br_ready),
    .br_opcode(br_opcode), .br_pc(br_pc), .br_target(br_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .link_we(link_we),
    .link_data(link_data), .resolved(resolved), .flags(flags), .stat_clr(stat_clr),
    .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit run_cmp = 0;

  // Behavioural model: busy countdown instead of a state machine.
  logic [3:0]  m_flags;
  int          m_hold;
  bit          m_res, m_rv, m_lwe, m_prev_acc, m_prev_tk;
  logic [31:0] m_rpc, m_ld;
  int          m_tc, m_nc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit spec_taken(input logic [5:0] op, input logic [3:0] f);
    bit z, s, c, v;
    z = f[0]; s = f[1]; c = f[2]; v = f[3];
    case (op)
      6'd8:               return s && !z;
      6'd9:               return z;
      6'd10:              return !z;
      6'd11, 6'd12, 6'd13: return 1'b1;
      6'd14:              return c;
      6'd15:              return !c;
      6'd16:              return v;
      6'd17:              return !s;
      default:            return 1'b0;
    endcase
  endfunction

  task automatic model_reset;
    m_flags = 4'b0; m_hold = 0; m_res = 0; m_rv = 0; m_lwe = 0;
    m_prev_acc = 0; m_prev_tk = 0; m_rpc = 0; m_ld = 0; m_tc = 0; m_nc = 0;
  endtask

  task automatic model_edge;
    bit acc, tk;
    acc = br_valid && (m_hold == 0);
    tk  = spec_taken(br_opcode, m_flags);
    if (stat_clr) begin
      m_tc = 0; m_nc = 0;
    end else if (m_prev_acc) begin
      if (m_prev_tk) m_tc = (m_tc < CMAX) ? m_tc + 1 : CMAX;
      else           m_nc = (m_nc < CMAX) ? m_nc + 1 : CMAX;
    end
    m_res = acc;
    m_rv  = acc && tk;
    if (m_rv) m_rpc = br_target;
    m_lwe = acc && (br_opcode == BL);
    if (m_lwe) m_ld = br_pc + 32'd4;
    if (acc)             m_hold = tk ? 1 + FL : 1;
    else if (m_hold > 0) m_hold = m_hold - 1;
    m_prev_acc = acc;
    m_prev_tk  = tk;
    if (flag_we) m_flags = {alu_ovf, alu_carry, alu_result[DATA_W-1], alu_result == 0};
  endtask

  task automatic compare_all;
    chk("br_ready",       br_ready,       rst_n && (m_hold == 0));
    chk("resolved",       resolved,       m_res);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc",    redirect_pc,    m_rpc);
    chk("link_we",        link_we,        m_lwe);
    chk("link_data",      link_data,      m_ld);
    chk("flags",          flags,          m_flags);
    chk("taken_cnt",      taken_cnt,      m_tc);
    chk("ntaken_cnt",     ntaken_cnt,     m_nc);
  endtask

  always @(negedge clk) if (run_cmp) compare_all();

  task automatic step;
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] tgt);
    br_valid = 1'b1; br_opcode = op; br_pc = pc; br_target = tgt;
    step();
    br_valid = 1'b0;
  endtask

  task automatic pulse_reset(input int cycles_low);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready",   br_ready,       1'b0);
    chk("rst_redir",   redirect_valid, 1'b0);
    chk("rst_resolved", resolved,      1'b0);
    chk("rst_link_we", link_we,        1'b0);
    chk("rst_rpc",     redirect_pc,    32'h0);
    chk("rst_ldata",   link_data,      32'h0);
    chk("rst_flags",   flags,          4'h0);
    chk("rst_tcnt",    taken_cnt,      2'd0);
    chk("rst_ncnt",    ntaken_cnt,     2'd0);
    repeat (cycles_low) step();
    rst_n = 1'b1;
    #1 chk("rst_release_ready", br_ready, 1'b1);
  endtask

  initial begin
    bit pend;
    int r;
    rst_n = 1'b1;
    alu_result = '0; alu_carry = 0; alu_ovf = 0; flag_we = 0;
    br_valid = 0; br_opcode = '0; br_pc = '0; br_target = '0; stat_clr = 0;
    model_reset();
    #1 rst_n = 1'b0;
    run_cmp = 1;
    repeat (2) step();
    rst_n = 1'b1;
    #1 chk("reset_ready_after_release", br_ready, 1'b1);

    // 1: BZ taken after Z set, 3-cycle ready drop
    flag_we = 1; alu_result = 32'h0;
    step();
    flag_we = 0;
    chk("t1_flags", flags, 4'b0001);
    send(BZ, 32'h10, 32'h100);
    chk("t1_redirect_valid", redirect_valid, 1'b1);
    chk("t1_redirect_pc", redirect_pc, 32'h100);
    chk("t1_resolved", resolved, 1'b1);
    chk("t1_ready_lo0", br_ready, 1'b0);
    step(); chk("t1_ready_lo1", br_ready, 1'b0);
    chk("t1_pulse_gone", redirect_valid, 1'b0);
    step(); chk("t1_ready_lo2", br_ready, 1'b0);
    step(); chk("t1_ready_back", br_ready, 1'b1);
    chk("t1_taken_cnt", taken_cnt, 2'd1);
    chk("t1_model_tc", m_tc, 1);

    // 2: BLT taken with S=1,Z=0, then not taken with alu_result=5
    flag_we = 1; alu_result = 32'h8000_0000;
    step();
    flag_we = 0;
    chk("t2_flags_s", flags, 4'b0010);
    send(BLT, 32'h20, 32'h40);
    chk("t2_taken", redirect_valid, 1'b1);
    chk("t2_rpc", redirect_pc, 32'h40);
    flag_we = 1; alu_result = 32'd5;
    step();
    flag_we = 0;
    step(); step();
    chk("t2_ready", br_ready, 1'b1);
    chk("t2_flags_clear", flags, 4'b0000);
    send(BLT, 32'h24, 32'h80);
    chk("t2_nt_resolved", resolved, 1'b1);
    chk("t2_nt_redirect", redirect_valid, 1'b0);
    chk("t2_rpc_hold", redirect_pc, 32'h40);
    step();
    chk("t2_ready_1cyc", br_ready, 1'b1);
    chk("t2_ntaken_cnt", ntaken_cnt, 2'd1);
    chk("t2_model_nc", m_nc, 1);

    // 3: BL with link wrap
    send(BL, 32'hFFFF_FFFC, 32'h200);
    chk("t3_link_we", link_we, 1'b1);
    chk("t3_link_data", link_data, 32'h0);
    chk("t3_rpc", redirect_pc, 32'h200);
    step();
    chk("t3_link_we_off", link_we, 1'b0);
    step(); step();
    chk("t3_taken_cnt", taken_cnt, 2'd3);

    // 4: same-cycle flag write uses old flags
    flag_we = 1; alu_result = 32'h0;
    send(BNZ, 32'h30, 32'h300);
    flag_we = 0;
    chk("t4_old_flags_taken", redirect_valid, 1'b1);
    chk("t4_new_flags", flags, 4'b0001);
    step(); step(); step();

    // 5: saturation and clear-over-increment
    send(B, 32'h40, 32'h500);
    step(); step(); step();
    chk("t5_saturated", taken_cnt, 2'd3);
    send(B, 32'h44, 32'h504);
    stat_clr = 1;
    step();
    stat_clr = 0;
    chk("t5_clr_taken", taken_cnt, 2'd0);
    chk("t5_clr_ntaken", ntaken_cnt, 2'd0);
    step(); step();
    for (int i = 0; i < 5; i++) begin
      send(B, 32'h100 + 32'(i), 32'h600 + 32'(i));
      step(); step(); step();
      chk("t5_count_seq", taken_cnt, (i + 1 < 3) ? i + 1 : 3);
    end

    // 6: reset during flush, then an unknown opcode
    send(B, 32'h0, 32'h400);
    step();
    pulse_reset(2);
    step();
    chk("t6_no_stale_redirect", redirect_valid, 1'b0);
    chk("t6_no_stale_resolved", resolved, 1'b0);
    send(UNK, 32'h50, 32'h700);
    chk("t6_unk_resolved", resolved, 1'b1);
    chk("t6_unk_not_taken", redirect_valid, 1'b0);
    step();
    chk("t6_unk_ready", br_ready, 1'b1);
    chk("t6_unk_ntaken", ntaken_cnt, 2'd1);

    // Random traffic against the model
    pend = 0;
    for (int i = 0; i < 3000; i++) begin
      flag_we    = ($urandom_range(0, 2) == 0);
      alu_result = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      alu_carry  = $urandom_range(0, 1);
      alu_ovf    = $urandom_range(0, 1);
      stat_clr   = ($urandom_range(0, 39) == 0);
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1;
        r = $urandom_range(0, 11);
        br_opcode = (r < 10) ? 6'(8 + r) : 6'($urandom);
        br_pc     = $urandom;
        br_target = $urandom;
      end
      br_valid = pend;
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset(1);
      end else begin
        step();
        if (m_prev_acc) pend = 0;
      end
    end
    br_valid = 0; flag_we = 0; stat_clr = 0;
    step(); step();
    run_cmp = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle jump-condition decoder.
- Holds an architectural flag register (Z, S, C, V) written by the ALU, and accepts branch requests over a valid/ready handshake.
- Resolves each branch one cycle after acceptance, emits a registered PC redirect and link write, then holds off further requests for a programmable flush window.
- Sits between the ALU/execute stage and PC/fetch control; also carries saturating taken/not-taken statistics counters.

Parameters:
DATA_W, 32, ALU result width; flag source width.
PC_W, 32, program counter / target width.
FLUSH_CYCLES, 2, cycles br_ready stays low after a taken branch (0 = no flush window).
CNT_W, 16, width of each statistics counter.
FLAG_MODE, 1, 1 = conditions use the flag register; 0 = conditions use the live alu_result/alu_carry/alu_ovf inputs.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
alu_result  input  DATA_W  ALU result for flag update / live mode
alu_carry  input  1  ALU carry-out
alu_ovf  input  1  ALU signed overflow
flag_we  input  1  latch Z,S,C,V from ALU inputs this cycle
br_valid  input  1  branch request valid
br_ready  output  1  unit can accept a request
br_opcode  input  6  branch opcode
br_pc  input  PC_W  PC of branch instruction
br_target  input  PC_W  resolved target address
redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  output  PC_W  redirect target
link_we  output  1  one-cycle pulse: write link_data to link register
link_data  output  PC_W  br_pc + 4 (mod 2^PC_W)
resolved  output  1  one-cycle pulse: a branch finished resolving (taken or not)
flags  output  4  {V,C,S,Z} flag register
stat_clr  input  1  synchronous clear of statistics counters
taken_cnt  output  CNT_W  saturating count of taken branches
ntaken_cnt  output  CNT_W  saturating count of not-taken branches

Behaviour:
- Reset (async, rst_n=0): state=IDLE, flags=0, all pulses 0, redirect_pc=0, link_data=0, counters=0. br_ready=0 while rst_n=0 and 1 in the first cycle after release.
- Flags: on flag_we at a clock edge: Z = (alu_result==0), S = alu_result[DATA_W-1], C = alu_carry, V = alu_ovf.
- Condition source:
  - FLAG_MODE=1: the flag register value before the same-edge flag_we update. A branch accepted in the same cycle as flag_we sees the old flags.
  - FLAG_MODE=0: live inputs sampled at acceptance.
- Conditions by opcode:
  - 001000 BLT: S & ~Z
  - 001001 BZ: Z
  - 001010 BNZ: ~Z
  - 001011 BR: always
  - 001100 B: always
  - 001101 BL: always, plus link
  - 001110 BCY: C
  - 001111 BNCY: ~C
  - 010000 BOV: V
  - 010001 BGE: ~S
  - any other opcode: not taken, still resolved.
- Handshake: accept when br_valid & br_ready. Requests are not queued. br_valid while br_ready=0 is ignored, and the requester must hold it.
- Timing from acceptance at edge N:
  - at edge N+1, resolved=1 for one cycle.
  - if taken: redirect_valid=1 and redirect_pc=br_target for one cycle.
  - for BL: link_we=1 and link_data=br_pc+4, coincident with the redirect.
  - redirect_pc and link_data hold their values between pulses.
- State machine:
  - IDLE: br_ready=1. Accept → RESOLVE.
  - RESOLVE (1 cycle): br_ready=0; drives the pulses.
    - taken & FLUSH_CYCLES>0 → FLUSH with counter=FLUSH_CYCLES.
    - otherwise → IDLE.
  - FLUSH: br_ready=0; counter decrements each cycle; at 1 → IDLE.
  - Not-taken throughput: one branch per 2 cycles. Taken: one per 2+FLUSH_CYCLES cycles.
- Counters: increment taken_cnt or ntaken_cnt in the RESOLVE cycle. Saturate at 2^CNT_W-1 with no wrap. stat_clr has priority over increment in the same cycle.
- Reset mid-operation: pending pulses are dropped, FSM returns to IDLE, flush counter is cleared.
- flag_we during RESOLVE or FLUSH updates flags normally; it does not affect the branch already resolving.

Test Plan:
1. Reset, then flag_we with alu_result=0. Accept BZ (001001), br_target=0x100 → one cycle later redirect_valid=1, redirect_pc=0x100, resolved=1. br_ready low for 3 cycles (FLUSH_CYCLES=2); taken_cnt=1.
2. flags S=1,Z=0; BLT to 0x40 → taken. Then flag_we with alu_result=5; BLT → resolved=1, redirect_valid=0, ntaken_cnt=1, br_ready back after 1 cycle.
3. BL with br_pc=0xFFFFFFFC, target 0x200 → link_we=1, link_data=0x00000000 (wrap), redirect_pc=0x200.
4. Same-cycle flag_we (alu_result=0) and BNZ accept with old Z=0 → taken (old flags used); flags then read Z=1.
5. CNT_W=2: 5 taken branches → taken_cnt saturates at 3. stat_clr asserted together with a resolve → counter reads 0.
6. rst_n low during FLUSH → br_ready=0 and all outputs 0 while low. After release, br_ready=1 immediately and no stale redirect pulse. Unknown opcode 111111 → resolved=1, redirect_valid=0.
